seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 27000: clock cycles per digit slot (1 kHz per digit at 27 MHz).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: cycles at the start of each slot with every digit off, to prevent ghosting.
REQ-003 SHALL have parameter BLANK_LEADING, default 1: 1 enables leading-zero blanking.
REQ-004 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 inverts seg and dp at the pins.
REQ-005 SHALL have parameter DIG_ACTIVE_LOW, default 1: 1 inverts dig at the pins.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port bcd, input, 16 bits: four BCD digits from bin2bcd; [3:0] is the least significant digit (digit 0).
REQ-009 SHALL have port dp_in, input, 4 bits: decimal point request per digit.
REQ-010 SHALL have port load, input, 1 bit: single-cycle strobe that captures bcd and dp_in.
REQ-011 SHALL have port seg, output, 7 bits: segments, bit0=a through bit6=g.
REQ-012 SHALL have port dp, output, 1 bit: decimal point segment.
REQ-013 SHALL have port dig, output, 4 bits: digit enables; dig[i] drives digit i.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full 4-digit frame.

Function
REQ-015 SHALL have slot counter cnt counting 0..SCAN_DIV-1 and wrapping to 0; digit index idx (2 bits) SHALL advance 0->1->2->3->0 on each wrap.
REQ-016 SHALL, on a load cycle, write bcd and dp_in into a pending register and set pend_v; a later load before the frame boundary SHALL overwrite the pending value (last load wins).
REQ-017 SHALL define the frame boundary as the cycle with idx==3 and cnt==SCAN_DIV-1; at that cycle the display register SHALL take pending if pend_v=1 and pend_v SHALL clear.
REQ-018 SHALL, when load coincides with the frame boundary, load the current bcd/dp_in directly into the display register and leave pend_v clear.
REQ-019 SHALL never change the display register at any time other than the frame boundary (no tearing within a frame).
REQ-020 SHALL drive all digits inactive and seg/dp inactive while cnt<BLANK_CYCLES; otherwise exactly one digit (idx) SHALL be active.
REQ-021 SHALL decode each nibble (active-high) as 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F; nibbles A-F SHALL display a dash (40).
REQ-022 SHALL, with BLANK_LEADING=1, blank digit k (k=3,2,1; seg=00) when digit k and every higher digit are 0; digit 0 SHALL never be blanked; dp SHALL follow dp_in and is unaffected by blanking.
REQ-023 SHALL register seg, dp and dig, so that the pins reflect the cnt/idx state of the previous cycle, with polarity applied after the register.
REQ-024 SHALL assert frame_done (registered) for exactly the one cycle following the frame boundary.
REQ-025 SHALL require SCAN_DIV>BLANK_CYCLES and BLANK_CYCLES>=1; other values are unsupported.

Reset
REQ-026 SHALL, while rst_n=0, asynchronously force cnt=0, idx=0, display=0, pending=0, pend_v=0, frame_done=0, and drive all dig, seg and dp outputs to their inactive levels.
REQ-027 SHALL, after rst_n deasserts, hold all outputs inactive for BLANK_CYCLES+1 cycles, then show digit 0 as "0" (3F) and digits 1-3 blanked.
REQ-028 SHALL discard any pending load when reset asserts mid-frame.

Verification (SCAN_DIV=8, BLANK_CYCLES=2, active-high polarities)
REQ-029 SHALL cover: load bcd=16'h1234 mid-frame -> the current frame is unchanged; the next frame shows dig 0001:66, 0010:4F, 0100:5B, 1000:06, each for 6 cycles after 2 blank cycles.
REQ-030 SHALL cover: bcd=16'h0007 -> digits 3-2-1 seg=00, digit 0 seg=07; bcd=16'h0000 -> only digit 0 shows 3F; with BLANK_LEADING=0 -> all four show 3F.
REQ-031 SHALL cover: load 16'h1111 then 16'h2222 in the same frame -> 2222 is displayed; load coincident with the frame boundary -> that value is displayed in the immediately following frame.
REQ-032 SHALL cover: bcd=16'h9A0F -> digits show 3..0 as 6F, 40, 3F, 40; dp_in=4'b0100 -> dp=1 only during the digit-2 active window.
REQ-033 SHALL cover: frame_done period = 32 cycles, one-cycle width, and at most one dig bit high in any cycle (assertion).
REQ-034 SHALL cover: rst_n pulsed low mid-slot with a pending load -> outputs go inactive immediately; after release, "0" is shown and the pending value never appears.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Multiplexed 4-digit seven-segment scanner with anti-ghost blanking, leading-zero
// suppression and tear-free display updates taken only at frame boundaries.
module seg7_scan_driver #(
    parameter int unsigned SCAN_DIV       = 27000,
    parameter int unsigned BLANK_CYCLES   = 16,
    parameter int unsigned BLANK_LEADING  = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bcd,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  dig,
    output logic        frame_done
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [19:0]   pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [19:0]   disp_q, disp_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    dig_q, dig_d;
    logic          frame_done_q, frame_done_d;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nib;
    logic [3:0]    dp_sel;
    logic          lead_zero;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_MAX);
        frame_end = slot_end && (idx_q == 2'd3);
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
    end

    // A load on the boundary cycle bypasses the pending stage so it shows next frame.
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        disp_d   = disp_q;
        if (frame_end) begin
            pend_v_d = 1'b0;
            if (load) begin
                disp_d = {dp_in, bcd};
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end
        end else if (load) begin
            pend_d   = {dp_in, bcd};
            pend_v_d = 1'b1;
        end
    end

    always_comb begin
        nib    = disp_q[{idx_q, 2'b00} +: 4];
        dp_sel = disp_q[19:16];
        unique case (idx_q)
            2'd3:    lead_zero = (disp_q[15:12] == 4'd0);
            2'd2:    lead_zero = (disp_q[15:8] == 8'd0);
            2'd1:    lead_zero = (disp_q[15:4] == 12'd0);
            default: lead_zero = 1'b0;
        endcase

        seg_d        = 7'h00;
        dp_d         = 1'b0;
        dig_d        = 4'b0000;
        frame_done_d = frame_end;
        if (cnt_q >= BLANK_END) begin
            dig_d = 4'b0001 << idx_q;
            dp_d  = dp_sel[idx_q];
            seg_d = ((BLANK_LEADING != 0) && lead_zero) ? 7'h00 : decode(nib);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            pend_q       <= 20'h0;
            pend_v_q     <= 1'b0;
            disp_q       <= 20'h0;
            seg_q        <= 7'h00;
            dp_q         <= 1'b0;
            dig_q        <= 4'b0000;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            disp_q       <= disp_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Registers hold active-high values; pin polarity is applied afterwards.
    assign seg        = seg_q ^ {7{SEG_INV}};
    assign dp         = dp_q ^ SEG_INV;
    assign dig        = dig_q ^ {4{DIG_INV}};
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver: a frame-level model (last load of a frame is
// displayed in the next frame) predicts every output cycle of two differently configured DUTs.
module tb_seg7_scan_driver;

    localparam int D     = 8;
    localparam int B     = 2;
    localparam int FRAME = 4 * D;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] bcd;
    logic [3:0]  dp_in;
    logic        load;

    logic [6:0]  seg, seg_n;
    logic        dp, dp_n;
    logic [3:0]  dig, dig_n;
    logic        fd, fd_n;

    int compared   = 0;
    int mismatched = 0;
    int t_cur      = 0;

    logic [19:0] last_load [int];
    logic [6:0]  seg_tab [16];
    logic [12:0] exp_a, exp_b, got_a, got_b;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .SCAN_DIV(D), .BLANK_CYCLES(B), .BLANK_LEADING(1), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_in(dp_in), .load(load),
        .seg(seg), .dp(dp), .dig(dig), .frame_done(fd)
    );

    seg7_scan_driver #(
        .SCAN_DIV(D), .BLANK_CYCLES(B), .BLANK_LEADING(0), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_nl (
        .clk(clk), .rst_n(rst_n), .bcd(bcd), .dp_in(dp_in), .load(load),
        .seg(seg_n), .dp(dp_n), .dig(dig_n), .frame_done(fd_n)
    );

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            compared++;
            assert ($countones(dig) <= 1)
            else begin
                mismatched++;
                $display("FAIL dig_onehot t=%0t: got dig=%b required at most one bit", $time, dig);
            end
        end
    end

    function automatic logic [19:0] disp_for(input int f);
        for (int k = f - 1; k >= 0; k--) begin
            if (last_load.exists(k)) return last_load[k];
        end
        return 20'h0;
    endfunction

    // Expected {frame_done, dp, dig, seg} (active-high) after the edge ending cycle p.
    function automatic logic [12:0] model(input int p, input bit lead);
        logic [19:0] v;
        logic [15:0] upper;
        logic [6:0]  s;
        logic        f;
        int          idx;
        idx = (p / D) % 4;
        v   = disp_for(p / FRAME);
        f   = ((p % FRAME) == FRAME - 1);
        if ((p % D) < B) return {f, 12'h000};
        upper = v[15:0] >> (4 * idx);
        s = (lead && idx > 0 && upper == 16'h0) ? 7'h00 : seg_tab[upper[3:0]];
        return {f, v[16 + idx], 4'(1 << idx), s};
    endfunction

    task automatic step(input logic ld, input logic [15:0] b, input logic [3:0] d);
        int          p;
        logic [12:0] e;
        load  = ld;
        bcd   = b;
        dp_in = d;
        @(posedge clk);
        p = t_cur;
        if (ld) last_load[p / FRAME] = {d, b};
        #1;
        load  = 1'b0;
        exp_a = model(p, 1'b1);
        e     = model(p, 1'b0);
        exp_b = {e[12], ~e[11:0]};
        got_a = {fd, dp, dig, seg};
        got_b = {fd_n, dp_n, dig_n, seg_n};
        t_cur++;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({fd, dp, dig, seg} !== 13'h0) begin
            mismatched++;
            $display("FAIL reset_hold_a: got %h required %h", {fd, dp, dig, seg}, 13'h0);
        end
        compared++;
        if ({fd_n, dp_n, dig_n, seg_n} !== 13'h0FFF) begin
            mismatched++;
            $display("FAIL reset_hold_b: got %h required %h", {fd_n, dp_n, dig_n, seg_n}, 13'h0FFF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t_cur = 0;
        last_load.delete();
        for (int i = 0; i < FRAME + 2; i++) begin
            step(1'b0, 16'h0, 4'h0);
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL reset_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL reset_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
            end
            if (t_cur - 1 == B) begin
                compared++;
                if (got_a !== {2'b00, 4'b0001, 7'h3F}) begin
                    mismatched++;
                    $display("FAIL reset_digit0: got %h required %h", got_a, {2'b00, 4'b0001, 7'h3F});
                end
            end
        end
    endtask

    task automatic test_scan_1234();
        int          lf;
        logic [6:0]  lit [4];
        lit = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        while (t_cur % FRAME != 10) step(1'b0, 16'h0, 4'h0);
        lf = t_cur / FRAME;
        step(1'b1, 16'h1234, 4'h0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'hFFFF, 4'hF);
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL scan_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL scan_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
            end
            if ((t_cur - 1) / FRAME == lf + 1 && (t_cur - 1) % D >= B) begin
                compared++;
                if (seg !== lit[((t_cur - 1) / D) % 4]) begin
                    mismatched++;
                    $display("FAIL scan_1234_lit p=%0d: got %h required %h", t_cur - 1, seg,
                             lit[((t_cur - 1) / D) % 4]);
                end
            end
        end
    endtask

    task automatic test_leading();
        logic [15:0] vals [2];
        vals = '{16'h0007, 16'h0000};
        for (int v = 0; v < 2; v++) begin
            while (t_cur % FRAME != 4) step(1'b0, 16'h0, 4'h0);
            step(1'b1, vals[v], 4'h0);
            for (int i = 0; i < 2 * FRAME; i++) begin
                step(1'b0, 16'h0, 4'h0);
                compared++;
                if (got_a !== exp_a) begin
                    mismatched++;
                    $display("FAIL leading_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
                end
                compared++;
                if (got_b !== exp_b) begin
                    mismatched++;
                    $display("FAIL leading_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
                end
            end
        end
    endtask

    task automatic test_last_load();
        while (t_cur % FRAME != 3) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h1111, 4'h1);
        while (t_cur % FRAME != 20) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h2222, 4'h2);
        while (t_cur % FRAME != FRAME - 1) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h5678, 4'h8);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0);
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL last_load_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL last_load_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
            end
        end
    endtask

    task automatic test_dash_dp();
        while (t_cur % FRAME != 7) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h9A0F, 4'b0100);
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0);
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL dash_dp_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL dash_dp_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
            end
        end
    endtask

    task automatic test_frame_done();
        int first = -1;
        int second = -1;
        for (int i = 0; i < 3 * FRAME && second < 0; i++) begin
            step(1'b0, 16'h0, 4'h0);
            if (fd === 1'b1) begin
                if (first < 0) first = t_cur - 1;
                else second = t_cur - 1;
            end
        end
        compared++;
        if (second < 0 || second - first != FRAME) begin
            mismatched++;
            $display("FAIL frame_done_period: got %0d required %0d", second - first, FRAME);
        end
        step(1'b0, 16'h0, 4'h0);
        compared++;
        if (fd !== 1'b0) begin
            mismatched++;
            $display("FAIL frame_done_width: got %b required 0", fd);
        end
    endtask

    task automatic test_reset_pending();
        while (t_cur % FRAME != 5) step(1'b0, 16'h0, 4'h0);
        step(1'b1, 16'h4321, 4'hF);
        repeat (6) step(1'b0, 16'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        compared++;
        if ({fd, dp, dig, seg} !== 13'h0) begin
            mismatched++;
            $display("FAIL rst_pend_now_a: got %h required %h", {fd, dp, dig, seg}, 13'h0);
        end
        compared++;
        if ({fd_n, dp_n, dig_n, seg_n} !== 13'h0FFF) begin
            mismatched++;
            $display("FAIL rst_pend_now_b: got %h required %h", {fd_n, dp_n, dig_n, seg_n}, 13'h0FFF);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t_cur = 0;
        last_load.delete();
        for (int i = 0; i < 2 * FRAME; i++) begin
            step(1'b0, 16'h0, 4'h0);
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL rst_pend_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL rst_pend_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12 * FRAME; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
            compared++;
            if (got_a !== exp_a) begin
                mismatched++;
                $display("FAIL random_a p=%0d: got %h required %h", t_cur - 1, got_a, exp_a);
            end
            compared++;
            if (got_b !== exp_b) begin
                mismatched++;
                $display("FAIL random_b p=%0d: got %h required %h", t_cur - 1, got_b, exp_b);
            end
        end
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        rst_n = 1'b0;
        load  = 1'b0;
        bcd   = 16'h0;
        dp_in = 4'h0;
        test_reset();
        test_scan_1234();
        test_leading();
        test_last_load();
        test_dash_dp();
        test_frame_done();
        test_reset_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
